// File: rtl/gpio_ip.sv
// gpio_ip: single 32-bit GPIO output register with strobe-based write and registered read-back.
// Define GPIO_RDATA_CLEAR_EN to make rdata a one-cycle pulse that clears whenever rd_en is low.
module gpio_ip #(
  parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] gpio_data
);

  logic [31:0] r_gpioReg;
  logic [31:0] r_rdata;

  // Register load; wdata is ignored unless wr_en is high.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_gpioReg <= RESET_VALUE;
    end else if (wr_en) begin
      r_gpioReg <= wdata;
    end
  end

  // Read captures the pre-edge register value, so a simultaneous write is never forwarded.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rdata <= 32'h0;
    end else if (rd_en) begin
      r_rdata <= r_gpioReg;
    end else begin
`ifdef GPIO_RDATA_CLEAR_EN
      r_rdata <= 32'h0;
`else
      r_rdata <= r_rdata;
`endif
    end
  end

  assign gpio_data = r_gpioReg;
  assign rdata     = r_rdata;

endmodule

// File: tb/tb_gpio_ip.sv
// tb_gpio_ip: directed-vector bench for gpio_ip; inputs change on the falling edge,
// outputs are checked 1 time unit after the rising edge.
module tb_gpio_ip;

  logic        clk;
  logic        resetn;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] gpio_data;

  int checkCount;
  int failCount;

  gpio_ip #(.RESET_VALUE(32'h0000_0000)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .wdata     (wdata),
    .rdata     (rdata),
    .gpio_data (gpio_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 32'h%08h, expected 32'h%08h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of strobes on the falling edge, then settle just past the rising edge.
  task automatic applyStimulus(input logic wr, input logic rd, input logic [31:0] data);
    @(negedge clk);
    wr_en = wr;
    rd_en = rd;
    wdata = data;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] idleRdata;

  initial begin
    checkCount = 0;
    failCount  = 0;
`ifdef GPIO_RDATA_CLEAR_EN
    idleRdata = 32'h0;
`else
    idleRdata = 32'h5;
`endif

    resetn = 1'b0;
    wr_en  = 1'b0;
    rd_en  = 1'b0;
    wdata  = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_gpio", gpio_data, 32'h0);
    checkOutput("reset_rdata", rdata, 32'h0);

    @(negedge clk);
    resetn = 1'b1;

    applyStimulus(1'b1, 1'b0, 32'h0000_0005);
    checkOutput("write5_gpio", gpio_data, 32'h5);
    checkOutput("write5_rdata_untouched", rdata, 32'h0);

    applyStimulus(1'b0, 1'b0, 32'hFFFF_FFFF);
    checkOutput("no_wr_hold", gpio_data, 32'h5);

    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFF);
    checkOutput("read5", rdata, 32'h5);

    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("idle_rdata", rdata, idleRdata);

    applyStimulus(1'b1, 1'b1, 32'h0000_000A);
    checkOutput("simul_rdata_old", rdata, 32'h5);
    checkOutput("simul_gpio_new", gpio_data, 32'hA);

    // Asynchronous reset between edges while a write is pending.
    @(negedge clk);
    wr_en  = 1'b1;
    rd_en  = 1'b0;
    wdata  = 32'h1234_5678;
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("async_rst_gpio", gpio_data, 32'h0);
    checkOutput("async_rst_rdata", rdata, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("rst_blocks_write", gpio_data, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    wr_en  = 1'b0;

    applyStimulus(1'b1, 1'b0, 32'h0000_0007);
    checkOutput("post_rst_write7", gpio_data, 32'h7);

    applyStimulus(1'b1, 1'b0, 32'h0000_0001);
    checkOutput("b2b_1", gpio_data, 32'h1);
    applyStimulus(1'b1, 1'b0, 32'h0000_0002);
    checkOutput("b2b_2", gpio_data, 32'h2);
    applyStimulus(1'b1, 1'b0, 32'h0000_0003);
    checkOutput("b2b_3", gpio_data, 32'h3);
    applyStimulus(1'b0, 1'b1, 32'h0);
    checkOutput("b2b_read3", rdata, 32'h3);

    // Strobes held high across consecutive cycles act independently.
    applyStimulus(1'b1, 1'b1, 32'hA5A5_0008);
    checkOutput("held_rd_1", rdata, 32'h3);
    checkOutput("held_wr_1", gpio_data, 32'hA5A5_0008);
    applyStimulus(1'b1, 1'b1, 32'h5A5A_0009);
    checkOutput("held_rd_2", rdata, 32'hA5A5_0008);
    checkOutput("held_wr_2", gpio_data, 32'h5A5A_0009);

    applyStimulus(1'b0, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
